// File: rtl/mc_control_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The sequencer (master) reads the decoded opcode and datapath status and
// drives every mux select, write enable and memory request.
interface mc_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS control sequencer: a Moore FSM stepping each instruction
// through fetch/decode/execute/memory/writeback and driving the datapath
// mux selects and enables. Memory states hold until mem_ready.
module mc_control #(
    parameter logic [3:0] RESET_STATE = 4'd0  // encoding of FETCH
) (
    input logic          clk,
    input logic          reset,
    mc_control_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiEx   = 4'd10,
        StAddiWb   = 4'd11
    } state_t;

    state_t state_q, state_d;

    logic       pc_en_c, iord_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c;
    logic       reg_dst_c, mem_to_reg_c, alu_src_a_c, illegal_op_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    // State register; synchronous reset returns to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode (pc_en also looks at mem_ready/zero).
    always_comb begin
        state_d      = StFetch;
        pc_en_c      = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'd0;
        alu_op_c     = 2'b00;
        pc_source_c  = 2'd0;
        illegal_op_c = 1'b0;

        unique case (state_q)
            StFetch: begin
                // PC + 4 computed and loaded in the same cycle the word arrives.
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'd1;
                ir_write_c  = bus.mem_ready;
                pc_en_c     = bus.mem_ready;
                state_d     = bus.mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b_c = 2'd3;
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                    state_d = StMemAddr;
                end else if (bus.opcode == OP_RTYPE) begin
                    state_d = StExecute;
                end else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) begin
                    state_d = StBranch;
                end else if (bus.opcode == OP_J) begin
                    state_d = StJump;
                end else if (bus.opcode == OP_ADDI) begin
                    state_d = StAddiEx;
                end else begin
                    illegal_op_c = 1'b1;
                    state_d      = StFetch;
                end
            end
            StMemAddr: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'd2;
                if (bus.opcode == OP_LW) begin
                    state_d = StMemRead;
                end else if (bus.opcode == OP_SW) begin
                    state_d = StMemWrite;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRead: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                state_d    = bus.mem_ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            StMemWrite: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                state_d     = bus.mem_ready ? StFetch : StMemWrite;
            end
            StExecute: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_d     = StAluWb;
            end
            StAluWb: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            StBranch: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b01;
                pc_source_c = 2'd1;
                pc_en_c     = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
            end
            StJump: begin
                pc_source_c = 2'd2;
                pc_en_c     = 1'b1;
            end
            StAddiEx: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'd2;
                state_d     = StAddiWb;
            end
            StAddiWb: begin
                reg_write_c = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Reset suppresses every side effect in the same cycle; selects stay decoded.
    assign bus.pc_en      = pc_en_c & ~reset;
    assign bus.ir_write   = ir_write_c & ~reset;
    assign bus.reg_write  = reg_write_c & ~reset;
    assign bus.mem_write  = mem_write_c & ~reset;
    assign bus.mem_read   = mem_read_c & ~reset;
    assign bus.illegal_op = illegal_op_c & ~reset;
    assign bus.iord       = iord_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.pc_source  = pc_source_c;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: each instruction is expanded into the
// expected list of states (with memory waits), and every cycle the outputs are
// compared against a table of per-state control values.
module tb_mc_control;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3;
    localparam int S_MEM_WB = 4, S_MEM_WRITE = 5, S_EXECUTE = 6, S_ALU_WB = 7;
    localparam int S_BRANCH = 8, S_JUMP = 9, S_ADDI_EX = 10, S_ADDI_WB = 11;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_ADDI = 6'h08;

    logic clk = 1'b0;
    logic reset;

    mc_control_if bus ();

    mc_control #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fails   = 0;

    typedef struct {
        int st;
        bit fixed;  // mem_ready value is dictated by the wait pattern
        bit mr;
    } step_t;

    step_t path[$];

    function automatic logic [15:0] exp_ctrl(int st, logic [5:0] op, logic z, logic mr, logic rst);
        logic pe, io, rd, wr, irw, rw, dst, m2r, sa, il;
        logic [1:0] sb, aop, ps;
        pe = 0; io = 0; rd = 0; wr = 0; irw = 0; rw = 0; dst = 0; m2r = 0; sa = 0; il = 0;
        sb = 0; aop = 0; ps = 0;
        case (st)
            S_FETCH:     begin rd = 1; sb = 2'd1; irw = mr; pe = mr; end
            S_DECODE:    begin
                sb = 2'd3;
                il = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI});
            end
            S_MEM_ADDR:  begin sa = 1; sb = 2'd2; end
            S_MEM_READ:  begin rd = 1; io = 1; end
            S_MEM_WB:    begin rw = 1; m2r = 1; end
            S_MEM_WRITE: begin wr = 1; io = 1; end
            S_EXECUTE:   begin sa = 1; aop = 2'b10; end
            S_ALU_WB:    begin rw = 1; dst = 1; end
            S_BRANCH:    begin sa = 1; aop = 2'b01; ps = 2'd1; pe = (op == OP_BEQ) ? z : !z; end
            S_JUMP:      begin ps = 2'd2; pe = 1; end
            S_ADDI_EX:   begin sa = 1; sb = 2'd2; end
            S_ADDI_WB:   begin rw = 1; end
            default:     ;
        endcase
        if (rst) begin
            pe = 0; irw = 0; rw = 0; wr = 0; rd = 0; il = 0;
        end
        return {pe, io, rd, wr, irw, rw, dst, m2r, sa, sb, aop, ps, il};
    endfunction

    function automatic logic [15:0] obs_ctrl();
        return {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_step(int st, bit fixed, bit mr);
        step_t s;
        s.st = st; s.fixed = fixed; s.mr = mr;
        path.push_back(s);
    endtask

    // Memory state held for 'waits' not-ready cycles, then the ready cycle.
    task automatic push_mem(int st, int waits);
        for (int i = 0; i < waits; i++) push_step(st, 1'b1, 1'b0);
        push_step(st, 1'b1, 1'b1);
    endtask

    task automatic build_path(logic [5:0] op, int fw, int mw);
        path.delete();
        push_mem(S_FETCH, fw);
        push_step(S_DECODE, 1'b0, 1'b0);
        case (op)
            OP_LW:    begin push_step(S_MEM_ADDR, 0, 0); push_mem(S_MEM_READ, mw);
                            push_step(S_MEM_WB, 0, 0); end
            OP_SW:    begin push_step(S_MEM_ADDR, 0, 0); push_mem(S_MEM_WRITE, mw); end
            OP_RTYPE: begin push_step(S_EXECUTE, 0, 0); push_step(S_ALU_WB, 0, 0); end
            OP_BEQ, OP_BNE: push_step(S_BRANCH, 0, 0);
            OP_J:     push_step(S_JUMP, 0, 0);
            OP_ADDI:  begin push_step(S_ADDI_EX, 0, 0); push_step(S_ADDI_WB, 0, 0); end
            default:  ;
        endcase
    endtask

    // rst_pick < 0: no reset; otherwise reset lands on step (rst_pick % length).
    task automatic run_instr(logic [5:0] op, int fw, int mw, logic z, int rst_pick);
        int rst_at;
        build_path(op, fw, mw);
        rst_at = (rst_pick < 0) ? -1 : rst_pick % path.size();
        for (int k = 0; k < path.size(); k++) begin
            @(negedge clk);
            bus.opcode    = (path[k].st == S_FETCH) ? 6'($urandom) : op;
            bus.zero      = (path[k].st == S_BRANCH) ? z : 1'($urandom);
            bus.mem_ready = path[k].fixed ? path[k].mr : 1'($urandom);
            reset         = (k == rst_at);
            #1;
            check($sformatf("ctrl op=%h step=%0d st=%0d rst=%0b", op, k, path[k].st, reset),
                  obs_ctrl(), exp_ctrl(path[k].st, op, z, bus.mem_ready, reset));
            check($sformatf("state op=%h step=%0d", op, k), 16'(bus.state), 16'(path[k].st));
            if (k == rst_at) begin
                @(negedge clk);
                reset         = 1'b0;
                bus.mem_ready = 1'b0;
                bus.opcode    = 6'($urandom);
                #1;
                check($sformatf("state after reset op=%h", op), 16'(bus.state), 16'(S_FETCH));
                check("ctrl after reset", obs_ctrl(),
                      exp_ctrl(S_FETCH, bus.opcode, bus.zero, 1'b0, 1'b0));
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] ops [7] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
        logic [5:0] op;

        reset         = 1'b1;
        bus.opcode    = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset state", 16'(bus.state), 16'(S_FETCH));
        check("reset ctrl", obs_ctrl(), exp_ctrl(S_FETCH, 6'h00, 1'b0, 1'b1, 1'b1));

        // Directed scenarios.
        run_instr(OP_RTYPE, 0, 0, 1'b0, -1);
        run_instr(OP_LW,    0, 2, 1'b0, -1);
        run_instr(OP_BEQ,   0, 0, 1'b1, -1);
        run_instr(OP_BNE,   0, 0, 1'b1, -1);
        run_instr(OP_J,     0, 0, 1'b0, -1);
        run_instr(OP_ADDI,  0, 0, 1'b0, -1);
        run_instr(6'h3F,    0, 0, 1'b0, -1);
        run_instr(OP_SW,    1, 0, 1'b0, -1);
        // sw: FETCH, DECODE, MEM_ADDR, then reset on the first not-ready MEM_WRITE.
        run_instr(OP_SW,    0, 3, 1'b0, 3);

        // Randomized instruction stream with occasional illegal opcodes and resets.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1);
        end

        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("final state", 16'(bus.state), 16'(S_FETCH));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
